// File: rtl/bpu_gshare_if.sv
// bpu_gshare_if: fetch-side prediction and EX-side training bus of the gshare predictor.
interface bpu_gshare_if #(parameter int GHR_BITS = 8);
  logic                if_valid;
  logic [31:0]         if_pc;
  logic                pred_taken;
  logic [31:0]         pred_target;
  logic                pred_hit;
  logic [GHR_BITS-1:0] pred_ghr;
  logic                busy;
  logic                update_en;
  logic [31:0]         update_pc;
  logic                update_taken;
  logic [31:0]         update_target;
  logic [1:0]          update_kind;
  logic                update_mispredict;
  logic [GHR_BITS-1:0] update_ghr;
  modport master (
    output if_valid, if_pc, update_en, update_pc, update_taken, update_target,
           update_kind, update_mispredict, update_ghr,
    input  pred_taken, pred_target, pred_hit, pred_ghr, busy
  );
  modport slave (
    input  if_valid, if_pc, update_en, update_pc, update_taken, update_target,
           update_kind, update_mispredict, update_ghr,
    output pred_taken, pred_target, pred_hit, pred_ghr, busy
  );
endinterface

// File: rtl/bpu_gshare.sv
// bpu_gshare: gshare direction predictor + tagged BTB with GHR repair and post-reset table clear.
// Optional return address stack enabled by defining BPU_RAS_EN.
module bpu_gshare #(
  parameter int BHT_ENTRIES = 256,
  parameter int BTB_ENTRIES = 64,
  parameter int GHR_BITS    = 8,
  parameter int CTR_BITS    = 2,
  parameter int TAG_BITS    = 20
`ifdef BPU_RAS_EN
  , parameter int RAS_DEPTH = 8
`endif
) (
  input logic         clk,
  input logic         rst_n,
  bpu_gshare_if.slave bus
);
  localparam int BHTW  = $clog2(BHT_ENTRIES);
  localparam int BTBW  = $clog2(BTB_ENTRIES);
  localparam int CLR_N = BHT_ENTRIES > BTB_ENTRIES ? BHT_ENTRIES : BTB_ENTRIES;
  localparam int CLRW  = $clog2(CLR_N);
  localparam logic [1:0] BR = 2'b00, CALL = 2'b10, RET = 2'b11;
  localparam logic [CTR_BITS-1:0] WNT  = {1'b0, {(CTR_BITS-1){1'b1}}};
  localparam logic [CTR_BITS-1:0] CMAX = '1;
  typedef enum logic {CLEAR, READY} state_t;
  state_t              state, state_nx;
  logic [CLRW-1:0]     clr_idx, clr_nx;
  logic [GHR_BITS-1:0] ghr, ghr_nx;
  logic [CTR_BITS-1:0] bht [BHT_ENTRIES];
  logic                btb_valid [BTB_ENTRIES];
  logic [TAG_BITS-1:0] btb_tag [BTB_ENTRIES];
  logic [31:0]         btb_target [BTB_ENTRIES];
  logic [1:0]          btb_kind [BTB_ENTRIES];
  logic                ready, hit, taken, upd, spec, repair, bht_we, btb_we;
  logic [BTBW-1:0]     fi, ui_btb;
  logic [BHTW-1:0]     fi_bht, ui_bht;
  logic [1:0]          kind;
  logic [CTR_BITS-1:0] uctr, uctr_nx;
  logic [31:0]         target;
  logic                unused_bits;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state   <= CLEAR;
      clr_idx <= '0;
      ghr     <= '0;
    end else begin
      state   <= state_nx;
      clr_idx <= clr_nx;
      ghr     <= ghr_nx;
    end
  always_comb begin
    state_nx = state;
    clr_nx   = clr_idx;
    ghr_nx   = ghr;
    state_nx = (state == CLEAR && clr_idx == CLRW'(CLR_N - 1)) ? READY : state;
    clr_nx   = (state == CLEAR) ? clr_idx + 1'b1 : clr_idx;
    ghr_nx   = !ready ? '0 :
               repair ? GHR_BITS'({bus.update_ghr, bus.update_taken}) :
               spec   ? GHR_BITS'({ghr, taken}) : ghr;
  end
  assign ready  = state == READY;
  assign fi     = bus.if_pc[BTBW+1:2];
  assign fi_bht = bus.if_pc[BHTW+1:2] ^ BHTW'(ghr);
  assign kind   = btb_kind[fi];
  assign hit    = ready && btb_valid[fi] && btb_tag[fi] == bus.if_pc[31 -: TAG_BITS];
  assign taken  = hit && (kind != BR || bht[fi_bht][CTR_BITS-1]);
  assign spec   = bus.if_valid && hit && kind == BR;
  assign upd    = ready && bus.update_en;
  assign repair = upd && bus.update_mispredict && bus.update_kind == BR;
  assign bht_we = upd && bus.update_kind == BR;
  assign btb_we = upd && (bus.update_taken || bus.update_kind != BR);
  assign ui_btb = bus.update_pc[BTBW+1:2];
  assign ui_bht = bus.update_pc[BHTW+1:2] ^ BHTW'(bus.update_ghr);
  assign uctr   = bht[ui_bht];
  assign uctr_nx = bus.update_taken ? (uctr == CMAX ? uctr : uctr + 1'b1)
                                    : (uctr == '0 ? uctr : uctr - 1'b1);
  // Tables carry no reset; the CLEAR walk initialises them one index per cycle.
  always_ff @(posedge clk)
    if (!ready) begin
      bht[clr_idx[BHTW-1:0]]       <= WNT;
      btb_valid[clr_idx[BTBW-1:0]] <= 1'b0;
    end else begin
      if (bht_we) bht[ui_bht] <= uctr_nx;
      if (btb_we) begin
        btb_valid[ui_btb]  <= 1'b1;
        btb_tag[ui_btb]    <= bus.update_pc[31 -: TAG_BITS];
        btb_target[ui_btb] <= bus.update_target;
        btb_kind[ui_btb]   <= bus.update_kind;
      end
    end
`ifdef BPU_RAS_EN
  localparam int RASW = $clog2(RAS_DEPTH);
  logic [31:0]   ras [RAS_DEPTH];
  logic [RASW-1:0] sp;
  logic [RASW:0] cnt;
  logic          ras_use, push, pop;
  assign ras_use = hit && kind == RET && cnt != '0;
  assign push    = bus.if_valid && hit && kind == CALL;
  assign pop     = bus.if_valid && ras_use;
  assign target  = ras_use ? ras[sp - 1'b1] : btb_target[fi];
  // Pushing when full wraps onto the oldest slot; count saturates at depth.
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      sp  <= '0;
      cnt <= '0;
    end else if (push) begin
      sp  <= sp + 1'b1;
      cnt <= cnt == (RASW+1)'(RAS_DEPTH) ? cnt : cnt + 1'b1;
    end else if (pop) begin
      sp  <= sp - 1'b1;
      cnt <= cnt - 1'b1;
    end
  always_ff @(posedge clk)
    if (push) ras[sp] <= bus.if_pc + 32'd4;
`else
  assign target = btb_target[fi];
`endif
  assign bus.pred_hit    = hit;
  assign bus.pred_taken  = taken;
  assign bus.pred_target = target;
  assign bus.pred_ghr    = ghr;
  assign bus.busy        = !ready;
  assign unused_bits     = ^{bus.if_pc, bus.update_pc};
endmodule

// File: tb/tb_bpu_gshare.sv
// tb_bpu_gshare: directed and randomized checks of bpu_gshare against an array/queue reference model.
module tb_bpu_gshare;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;
  bpu_gshare_if #(.GHR_BITS(8)) bus();
  bpu_gshare dut (.clk(clk), .rst_n(rst_n), .bus(bus));
`ifdef BPU_RAS_EN
  localparam bit RAS_ON = 1'b1;
`else
  localparam bit RAS_ON = 1'b0;
`endif
  int total = 0;
  int bad = 0;
  int          m_ctr [256];
  bit          m_v [64];
  logic [19:0] m_tag [64];
  logic [31:0] m_tgt [64];
  logic [1:0]  m_kind [64];
  logic [7:0]  m_ghr;
  logic [31:0] m_ras [$];

  function automatic void m_clear();
    for (int i = 0; i < 256; i++) m_ctr[i] = 1;
    for (int i = 0; i < 64; i++) m_v[i] = 0;
    m_ghr = 8'h00;
    m_ras.delete();
  endfunction

  function automatic void m_predict(input logic [31:0] pc, output bit h, output bit t,
                                    output logic [31:0] tg, output logic [1:0] k);
    int i = int'((pc >> 2) % 64);
    int b = int'((pc >> 2) % 256) ^ int'(m_ghr);
    h  = m_v[i] && m_tag[i] == pc[31:12];
    k  = m_kind[i];
    t  = h && (k != 2'd0 || m_ctr[b] >= 2);
    tg = m_tgt[i];
    if (RAS_ON && h && k == 2'd3 && m_ras.size() > 0) tg = m_ras[$];
  endfunction

  task automatic idle();
    bus.if_valid = 0; bus.if_pc = 0; bus.update_en = 0; bus.update_pc = 0;
    bus.update_taken = 0; bus.update_target = 0; bus.update_kind = 0;
    bus.update_mispredict = 0; bus.update_ghr = 0;
  endtask

  task automatic set_upd(input logic [31:0] pc, input logic tk, input logic [31:0] tg,
                         input logic [1:0] k, input logic mp, input logic [7:0] g);
    bus.update_en = 1; bus.update_pc = pc; bus.update_taken = tk; bus.update_target = tg;
    bus.update_kind = k; bus.update_mispredict = mp; bus.update_ghr = g;
  endtask

  // Advance one clock in READY, applying the same inputs to the model.
  task automatic step();
    bit h, t;
    logic [31:0] tg;
    logic [1:0] k;
    logic [7:0] ng;
    int b, i;
    m_predict(bus.if_pc, h, t, tg, k);
    ng = m_ghr;
    if (bus.if_valid && h && k == 2'd0) ng = {m_ghr[6:0], t};
    if (bus.update_en && bus.update_mispredict && bus.update_kind == 2'd0)
      ng = {bus.update_ghr[6:0], bus.update_taken};
    if (RAS_ON && bus.if_valid && h && k == 2'd2) begin
      m_ras.push_back(bus.if_pc + 32'd4);
      if (m_ras.size() > 8) void'(m_ras.pop_front());
    end else if (RAS_ON && bus.if_valid && h && k == 2'd3 && m_ras.size() > 0)
      void'(m_ras.pop_back());
    if (bus.update_en && bus.update_kind == 2'd0) begin
      b = int'((bus.update_pc >> 2) % 256) ^ int'(bus.update_ghr);
      m_ctr[b] = bus.update_taken ? (m_ctr[b] == 3 ? 3 : m_ctr[b] + 1)
                                  : (m_ctr[b] == 0 ? 0 : m_ctr[b] - 1);
    end
    if (bus.update_en && (bus.update_taken || bus.update_kind != 2'd0)) begin
      i = int'((bus.update_pc >> 2) % 64);
      m_v[i] = 1; m_tag[i] = bus.update_pc[31:12];
      m_tgt[i] = bus.update_target; m_kind[i] = bus.update_kind;
    end
    @(posedge clk); #1;
    m_ghr = ng;
  endtask

  task automatic test_reset();
    int n;
    idle();
    rst_n = 0;
    repeat (3) @(posedge clk);
    #1;
    total += 4;
    if (bus.busy !== 1'b1) begin bad++; $display("FAIL rst_busy got=%b exp=1", bus.busy); end
    if (bus.pred_hit !== 1'b0) begin bad++; $display("FAIL rst_hit got=%b exp=0", bus.pred_hit); end
    if (bus.pred_taken !== 1'b0) begin bad++; $display("FAIL rst_taken got=%b exp=0", bus.pred_taken); end
    if (bus.pred_ghr !== 8'h00) begin bad++; $display("FAIL rst_ghr got=%h exp=00", bus.pred_ghr); end
    rst_n = 1;
    repeat (100) @(posedge clk);
    #1;
    rst_n = 0;
    #2;
    rst_n = 1;
    set_upd(32'h100, 1, 32'h200, 2'd0, 1, 8'hFF);
    bus.if_valid = 1; bus.if_pc = 32'h100;
    @(posedge clk); #1;
    n = 1;
    while (bus.busy === 1'b1 && n < 600) begin
      total++;
      if (bus.pred_hit !== 1'b0 || bus.pred_taken !== 1'b0 || bus.pred_ghr !== 8'h00) begin
        bad++;
        $display("FAIL clear_outputs cyc=%0d hit=%b taken=%b ghr=%h exp 0/0/00", n, bus.pred_hit, bus.pred_taken, bus.pred_ghr);
      end
      @(posedge clk); #1;
      n++;
    end
    total++;
    if (n !== 256) begin bad++; $display("FAIL busy_len got=%0d exp=256", n); end
    idle();
    bus.if_pc = 32'h100;
    #1;
    total += 2;
    if (bus.pred_hit !== 1'b0) begin bad++; $display("FAIL clear_ignores_update got=%b exp=0", bus.pred_hit); end
    if (bus.pred_ghr !== 8'h00) begin bad++; $display("FAIL clear_ghr got=%h exp=00", bus.pred_ghr); end
    m_clear();
  endtask

  task automatic test_train();
    idle(); set_upd(32'h100, 1, 32'h200, 2'd0, 0, 8'h00); step(); step();
    idle(); bus.if_pc = 32'h100; #1;
    total += 3;
    if (bus.pred_hit !== 1'b1) begin bad++; $display("FAIL train_hit got=%b exp=1", bus.pred_hit); end
    if (bus.pred_taken !== 1'b1) begin bad++; $display("FAIL train_taken got=%b exp=1", bus.pred_taken); end
    if (bus.pred_target !== 32'h200) begin bad++; $display("FAIL train_target got=%h exp=00000200", bus.pred_target); end
    idle(); set_upd(32'h100, 0, 32'h0, 2'd0, 0, 8'h00); step(); step();
    idle(); bus.if_pc = 32'h100; #1;
    total += 2;
    if (bus.pred_taken !== 1'b0) begin bad++; $display("FAIL untrain_taken got=%b exp=0", bus.pred_taken); end
    if (bus.pred_hit !== 1'b1) begin bad++; $display("FAIL untrain_hit got=%b exp=1", bus.pred_hit); end
  endtask

  task automatic test_saturate();
    idle(); set_upd(32'h100, 1, 32'h200, 2'd0, 0, 8'h00);
    repeat (5) step();
    set_upd(32'h100, 0, 32'h0, 2'd0, 0, 8'h00); step();
    idle(); bus.if_pc = 32'h100; #1;
    total++;
    if (bus.pred_taken !== 1'b1) begin bad++; $display("FAIL sat_one_nt got=%b exp=1", bus.pred_taken); end
    set_upd(32'h100, 0, 32'h0, 2'd0, 0, 8'h00); step();
    idle(); bus.if_pc = 32'h100; #1;
    total++;
    if (bus.pred_taken !== 1'b0) begin bad++; $display("FAIL sat_two_nt got=%b exp=0", bus.pred_taken); end
  endtask

  task automatic test_ghr();
    idle(); set_upd(32'h100, 1, 32'h200, 2'd0, 0, 8'h00); step();
    idle(); bus.if_valid = 1; bus.if_pc = 32'h100; #1;
    total += 2;
    if (bus.pred_taken !== 1'b1) begin bad++; $display("FAIL ghr_pre_taken got=%b exp=1", bus.pred_taken); end
    if (bus.pred_ghr !== 8'h00) begin bad++; $display("FAIL ghr_pre got=%h exp=00", bus.pred_ghr); end
    step();
    idle(); #1;
    total++;
    if (bus.pred_ghr !== 8'h01) begin bad++; $display("FAIL ghr_shift got=%h exp=01", bus.pred_ghr); end
    set_upd(32'h100, 0, 32'h0, 2'd0, 1, 8'h80); step();
    idle(); #1;
    total++;
    if (bus.pred_ghr !== 8'h00) begin bad++; $display("FAIL ghr_repair got=%h exp=00", bus.pred_ghr); end
    bus.if_valid = 1; bus.if_pc = 32'h100;
    set_upd(32'h300, 0, 32'h0, 2'd0, 1, 8'h0F); #1;
    total++;
    if (bus.pred_taken !== 1'b1) begin bad++; $display("FAIL ghr_both_taken got=%b exp=1", bus.pred_taken); end
    step();
    idle(); #1;
    total++;
    if (bus.pred_ghr !== 8'h1E) begin bad++; $display("FAIL ghr_repair_prio got=%h exp=1e", bus.pred_ghr); end
  endtask

  task automatic test_alias();
    idle(); bus.if_pc = 32'h0000_1100; #1;
    total++;
    if (bus.pred_hit !== 1'b0) begin bad++; $display("FAIL alias_hit got=%b exp=0", bus.pred_hit); end
    bus.if_pc = 32'h0000_0100; #1;
    total++;
    if (bus.pred_hit !== 1'b1) begin bad++; $display("FAIL alias_orig got=%b exp=1", bus.pred_hit); end
  endtask

  task automatic test_kinds();
    logic [31:0] pcs [4] = '{32'h504, 32'h508, 32'h40, 32'h80};
    logic [31:0] tgs [4] = '{32'h900, 32'h980, 32'h800, 32'h600};
    logic [1:0]  kds [4] = '{2'd1, 2'd1, 2'd2, 2'd3};
    logic        tks [4] = '{1'b1, 1'b0, 1'b1, 1'b1};
    for (int i = 0; i < 4; i++) begin
      idle(); set_upd(pcs[i], tks[i], tgs[i], kds[i], 0, 8'h00); step();
    end
    idle(); set_upd(32'h50C, 0, 32'hA00, 2'd0, 0, 8'h00); step();
    for (int i = 0; i < 4; i++) begin
      idle(); bus.if_pc = pcs[i]; #1;
      total += 3;
      if (bus.pred_hit !== 1'b1) begin bad++; $display("FAIL kind_hit pc=%h got=%b exp=1", pcs[i], bus.pred_hit); end
      if (bus.pred_taken !== 1'b1) begin bad++; $display("FAIL kind_taken pc=%h got=%b exp=1", pcs[i], bus.pred_taken); end
      if (bus.pred_target !== tgs[i]) begin bad++; $display("FAIL kind_target pc=%h got=%h exp=%h", pcs[i], bus.pred_target, tgs[i]); end
    end
    idle(); bus.if_pc = 32'h50C; #1;
    total++;
    if (bus.pred_hit !== 1'b0) begin bad++; $display("FAIL nt_br_alloc got=%b exp=0", bus.pred_hit); end
  endtask

  task automatic test_call_ret();
    logic [31:0] exp_t;
    idle(); bus.if_valid = 1; bus.if_pc = 32'h40; step();
    idle(); bus.if_valid = 1; bus.if_pc = 32'h80; #1;
    exp_t = RAS_ON ? 32'h44 : 32'h600;
    total += 2;
    if (bus.pred_taken !== 1'b1) begin bad++; $display("FAIL ret_taken got=%b exp=1", bus.pred_taken); end
    if (bus.pred_target !== exp_t) begin bad++; $display("FAIL ret_target got=%h exp=%h", bus.pred_target, exp_t); end
    step();
    idle();
  endtask

`ifdef BPU_RAS_EN
  task automatic test_ras_nested();
    logic [31:0] exp_t;
    for (int k = 0; k < 9; k++) begin
      idle(); set_upd(32'h10C0 + 32'(4 * k), 1, 32'h3000, 2'd2, 0, 8'h00); step();
    end
    for (int k = 0; k < 9; k++) begin
      idle(); bus.if_valid = 1; bus.if_pc = 32'h10C0 + 32'(4 * k); step();
    end
    for (int j = 0; j < 9; j++) begin
      idle(); bus.if_valid = 1; bus.if_pc = 32'h80; #1;
      exp_t = (j < 8) ? 32'h10C4 + 32'(4 * (8 - j)) : 32'h600;
      total++;
      if (bus.pred_target !== exp_t) begin bad++; $display("FAIL ras_nest j=%0d got=%h exp=%h", j, bus.pred_target, exp_t); end
      step();
    end
    idle();
  endtask
`endif

  task automatic test_random();
    bit h, t;
    logic [31:0] tg;
    logic [1:0] k;
    for (int c = 0; c < 400; c++) begin
      idle();
      bus.if_valid = 1'($urandom_range(0, 1));
      bus.if_pc = ($urandom_range(0, 1) << 12) | ($urandom_range(0, 15) << 2);
      if ($urandom_range(0, 1) == 1)
        set_upd(($urandom_range(0, 1) << 12) | ($urandom_range(0, 15) << 2),
                1'($urandom_range(0, 1)), $urandom & 32'hFFFF_FFFC,
                ($urandom_range(0, 3) == 0) ? 2'($urandom_range(1, 3)) : 2'd0,
                1'($urandom_range(0, 1)), 8'($urandom_range(0, 255)));
      #1;
      m_predict(bus.if_pc, h, t, tg, k);
      total += 2;
      if (bus.pred_hit !== h) begin bad++; $display("FAIL rnd_hit c=%0d pc=%h got=%b exp=%b", c, bus.if_pc, bus.pred_hit, h); end
      if (bus.pred_ghr !== m_ghr) begin bad++; $display("FAIL rnd_ghr c=%0d got=%h exp=%h", c, bus.pred_ghr, m_ghr); end
      if (h) begin
        total += 2;
        if (bus.pred_taken !== t) begin bad++; $display("FAIL rnd_taken c=%0d pc=%h got=%b exp=%b", c, bus.if_pc, bus.pred_taken, t); end
        if (bus.pred_target !== tg) begin bad++; $display("FAIL rnd_target c=%0d pc=%h got=%h exp=%h", c, bus.if_pc, bus.pred_target, tg); end
      end
      step();
    end
    idle();
  endtask

  task automatic test_ready_reset();
    int n;
    idle(); bus.if_pc = 32'h100;
    rst_n = 0;
    #2;
    total += 2;
    if (bus.busy !== 1'b1) begin bad++; $display("FAIL rrst_busy got=%b exp=1", bus.busy); end
    if (bus.pred_hit !== 1'b0) begin bad++; $display("FAIL rrst_hit got=%b exp=0", bus.pred_hit); end
    @(posedge clk); #1;
    rst_n = 1;
    n = 0;
    while (bus.busy === 1'b1 && n < 600) begin
      @(posedge clk); #1;
      n++;
    end
    total++;
    if (n !== 256) begin bad++; $display("FAIL rrst_len got=%0d exp=256", n); end
    #1;
    total++;
    if (bus.pred_hit !== 1'b0) begin bad++; $display("FAIL rrst_cleared got=%b exp=0", bus.pred_hit); end
  endtask

  initial begin
    idle();
    test_reset();
    test_train();
    test_saturate();
    test_ghr();
    test_alias();
    test_kinds();
    test_call_ret();
`ifdef BPU_RAS_EN
    test_ras_nested();
`endif
    test_random();
    test_ready_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
